// File: rtl/sram_sample_port.sv
// sram_sample_port: turns one sample tick into an SRAM read followed by an optional write on a shared async-SRAM bus.
module sram_sample_port #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 21,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  sample_tick_i,
  input  logic [ADDR_WIDTH-1:0] read_address_i,
  input  logic [ADDR_WIDTH-1:0] write_address_i,
  input  logic [DATA_WIDTH-1:0] writedata_i,
  input  logic                  write_enable_i,
  output logic [DATA_WIDTH-1:0] readdata_o,
  output logic                  readdata_valid_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  input  logic [DATA_WIDTH-1:0] sram_dq_i,
  output logic [DATA_WIDTH-1:0] sram_dq_o,
  output logic                  sram_dq_oe_o,
  output logic                  sram_ce_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o
);
  localparam int CW = $clog2((READ_WAIT > WRITE_WAIT ? READ_WAIT : WRITE_WAIT) + 1);
  typedef enum logic [2:0] {IDLE, READ, TURN, WRITE, WHOLD} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dq_q, dq_d, rdata_q, rdata_d;
  logic                  wen_q, wen_d, ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                  dq_oe_q, dq_oe_d, valid_q, valid_d, busy_q, busy_d, ovr_q, ovr_d;
  logic                  accept, start_write;
  always_comb begin
    accept = sample_tick_i && state_q == IDLE;
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = READ;
        cnt_d = CW'(READ_WAIT - 1);
      end
      READ: if (cnt_q == '0) state_d = TURN; else cnt_d = cnt_q - CW'(1);
      TURN: if (wen_q) begin
        state_d = WRITE;
        cnt_d = CW'(WRITE_WAIT - 1);
      end else state_d = IDLE;
      WRITE: if (cnt_q == '0) state_d = WHOLD; else cnt_d = cnt_q - CW'(1);
      default: state_d = IDLE;
    endcase
    start_write = state_q == TURN && state_d == WRITE;
    // Write data is parked on dq_o at accept time; it is only driven once dq_oe rises.
    waddr_d = accept ? write_address_i : waddr_q;
    wen_d = accept ? write_enable_i : wen_q;
    dq_d = accept ? writedata_i : dq_q;
    addr_d = accept ? read_address_i : start_write ? waddr_q : addr_q;
    ce_n_d = state_d == IDLE;
    oe_n_d = state_d != READ;
    we_n_d = state_d != WRITE;
    dq_oe_d = state_d == WRITE || state_d == WHOLD;
    valid_d = state_q == READ && cnt_q == '0;
    rdata_d = valid_d ? sram_dq_i : rdata_q;
    busy_d = state_d != IDLE;
    ovr_d = ovr_q || (sample_tick_i && state_q != IDLE);
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      waddr_q <= '0;
      wen_q <= 1'b0;
      dq_q <= '0;
      addr_q <= '0;
      rdata_q <= '0;
      ce_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      we_n_q <= 1'b1;
      dq_oe_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      waddr_q <= waddr_d;
      wen_q <= wen_d;
      dq_q <= dq_d;
      addr_q <= addr_d;
      rdata_q <= rdata_d;
      ce_n_q <= ce_n_d;
      oe_n_q <= oe_n_d;
      we_n_q <= we_n_d;
      dq_oe_q <= dq_oe_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      ovr_q <= ovr_d;
    end
  end
  assign readdata_o = rdata_q;
  assign readdata_valid_o = valid_q;
  assign busy_o = busy_q;
  assign overrun_o = ovr_q;
  assign sram_addr_o = addr_q;
  assign sram_dq_o = dq_q;
  assign sram_dq_oe_o = dq_oe_q;
  assign sram_ce_n_o = ce_n_q;
  assign sram_oe_n_o = oe_n_q;
  assign sram_we_n_o = we_n_q;
endmodule

// File: tb/tb_sram_sample_port.sv
// tb_sram_sample_port: directed and random read/write pairs against an SRAM model and a scoreboard memory.
module tb_sram_sample_port;
  localparam int RW = 2;
  localparam int WW = 2;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        sample_tick_i = 1'b0;
  logic [20:0] read_address_i = '0;
  logic [20:0] write_address_i = '0;
  logic [15:0] writedata_i = '0;
  logic        write_enable_i = 1'b0;
  logic [15:0] readdata_o, sram_dq_i, sram_dq_o;
  logic [20:0] sram_addr_o;
  logic        readdata_valid_o, busy_o, overrun_o, sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        ovr_model = 1'b0;
  bit   [15:0] sram_mem [0:(1<<21)-1];
  logic [15:0] ref_mem [logic [20:0]];

  sram_sample_port #(.DATA_WIDTH(16), .ADDR_WIDTH(21), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .sample_tick_i(sample_tick_i),
    .read_address_i(read_address_i), .write_address_i(write_address_i),
    .writedata_i(writedata_i), .write_enable_i(write_enable_i),
    .readdata_o(readdata_o), .readdata_valid_o(readdata_valid_o),
    .busy_o(busy_o), .overrun_o(overrun_o), .sram_addr_o(sram_addr_o),
    .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o), .sram_dq_oe_o(sram_dq_oe_o),
    .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o)
  );

  always #5 clk_i = ~clk_i;

  // Async SRAM model: combinational read while selected with outputs enabled, write while we_n is low.
  assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram_mem[sram_addr_o] : 16'h0;
  always @(posedge clk_i) if (!sram_ce_n_o && !sram_we_n_o && sram_dq_oe_o) sram_mem[sram_addr_o] <= sram_dq_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i)
    chk("bus_contention", {30'b0, !sram_oe_n_o && !sram_we_n_o, sram_dq_oe_o && !sram_oe_n_o}, 32'h0);

  function automatic logic [6:0] flags();
    return {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe_o, readdata_valid_o, busy_o, overrun_o};
  endfunction

  // Called in cycle 0 (after a posedge); returns at the sample point of the IDLE re-entry cycle.
  task automatic pair(input logic [20:0] ra, input logic [20:0] wa, input logic [15:0] wd,
                      input logic wen, input int ovr_c);
    logic [15:0] exp_rd;
    int last;
    exp_rd = ref_mem.exists(ra) ? ref_mem[ra] : 16'h0;
    if (wen) ref_mem[wa] = wd;
    last = wen ? RW + WW + 2 : RW + 1;
    read_address_i = ra;
    write_address_i = wa;
    writedata_i = wd;
    write_enable_i = wen;
    sample_tick_i = 1'b1;
    for (int c = 1; c <= last + 1; c++) begin
      @(posedge clk_i);
      #1;
      sample_tick_i = (c == ovr_c);
      read_address_i = 21'($urandom);
      write_address_i = 21'($urandom);
      writedata_i = 16'($urandom);
      write_enable_i = 1'($urandom);
      if (ovr_c > 0 && c == ovr_c + 1) ovr_model = 1'b1;
      @(negedge clk_i);
      if (c <= last) begin
        chk("strobes", {25'b0, flags()}, {25'b0, 1'b0, !(c <= RW), !(wen && c >= RW + 2 && c <= RW + WW + 1),
                                          wen && c >= RW + 2, c == RW + 1, 1'b1, ovr_model});
        chk("addr", {11'b0, sram_addr_o}, {11'b0, (c <= RW + 1) ? ra : wa});
        if (wen && c >= RW + 2) chk("dq_o", {16'b0, sram_dq_o}, {16'b0, wd});
        if (c == RW + 1) chk("readdata", {16'b0, readdata_o}, {16'b0, exp_rd});
      end else chk("idle_reentry", {25'b0, flags()}, {25'b0, 6'b111000, ovr_model});
    end
  endtask

  initial begin
    sram_mem[21'h00123] = 16'hBEEF;
    ref_mem[21'h00123] = 16'hBEEF;
    sram_mem[21'h00400] = 16'h1111;
    ref_mem[21'h00400] = 16'h1111;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_flags", {25'b0, flags()}, {25'b0, 7'b1110000});
    chk("reset_addr", {11'b0, sram_addr_o}, 32'h0);
    chk("reset_dq_o", {16'b0, sram_dq_o}, 32'h0);
    chk("reset_readdata", {16'b0, readdata_o}, 32'h0);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    // Abort a full pair during WRITE; the write must not land.
    read_address_i = 21'h00005;
    write_address_i = 21'h00003;
    writedata_i = 16'hFFFF;
    write_enable_i = 1'b1;
    sample_tick_i = 1'b1;
    for (int c = 1; c <= RW + 2; c++) begin
      @(posedge clk_i);
      #1 sample_tick_i = 1'b0;
    end
    chk("pre_abort_we_n", {31'b0, sram_we_n_o}, 32'h0);
    rst_n_i = 1'b0;
    #1;
    chk("abort_flags", {25'b0, flags()}, {25'b0, 7'b1110000});
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("post_abort_idle", {25'b0, flags()}, {25'b0, 7'b1110000});
    end
    chk("abort_no_write", {16'b0, sram_mem[21'h00003]}, 32'h0);
    @(posedge clk_i);
    #1;
    pair(21'h00007, 21'h00008, 16'h1234, 1'b1, 0);
    pair(21'h00123, 21'h00777, 16'h5555, 1'b0, 0);
    pair(21'h1FFFFF, 21'h000010, 16'hA5A5, 1'b1, 0);
    chk("full_pair_mem", {16'b0, sram_mem[21'h00010]}, 32'hA5A5);
    pair(21'h00400, 21'h00400, 16'h2222, 1'b1, 0);
    chk("same_addr_mem", {16'b0, sram_mem[21'h00400]}, 32'h2222);
    pair(21'h00008, 21'h00009, 16'h0F0F, 1'b1, 3);
    pair(21'h00009, 21'h0000A, 16'hC3C3, 1'b0, 0);
    for (int i = 0; i < 10000; i++)
      pair(21'h01000 + 21'($urandom_range(0, 255)), 21'h01000 + 21'($urandom_range(0, 255)),
           16'($urandom), 1'($urandom), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_sample_port.md
# sram_sample_port

Single-port asynchronous SRAM controller that sits directly downstream of the external-memory interface (write address, read address, writedata, write_enable, readdata). Once per audio sample it turns the interface's simultaneous read and write request into one SRAM read followed by an optional SRAM write on the shared bus. It then returns the read word as readdata.

## Interface
- DATA_WIDTH, 16, SRAM word width.
- ADDR_WIDTH, 21, SRAM word address width.
- READ_WAIT, 2, cycles the read strobe is held; minimum 1.
- WRITE_WAIT, 2, cycles we_n is held low; minimum 1.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- sample_tick_i  in  1  one-cycle strobe that starts a read/write pair.
- read_address_i  in  ADDR_WIDTH  read word address.
- write_address_i  in  ADDR_WIDTH  write word address.
- writedata_i  in  DATA_WIDTH  word to write.
- write_enable_i  in  1  when high at tick, the write phase runs.
- readdata_o  out  DATA_WIDTH  last word read; held until next valid.
- readdata_valid_o  out  1  one-cycle pulse when readdata_o updates.
- busy_o  out  1  high from the cycle after an accepted tick until back in IDLE.
- overrun_o  out  1  sticky; set when a tick arrives while busy.
- sram_addr_o  out  ADDR_WIDTH  SRAM address.
- sram_dq_i  in  DATA_WIDTH  SRAM data bus, input side.
- sram_dq_o  out  DATA_WIDTH  SRAM data bus, output side.
- sram_dq_oe_o  out  1  tristate enable for sram_dq_o (1 = FPGA drives).
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low SRAM strobes.

## Operation
- All outputs come straight from flops; there are no combinational paths from inputs to outputs.
- Reset values:
  - sram_ce_n_o, sram_oe_n_o, sram_we_n_o are all 1.
  - sram_dq_oe_o is 0.
  - sram_addr_o, sram_dq_o and readdata_o are 0.
  - readdata_valid_o, busy_o and overrun_o are 0.
  - The state machine is in IDLE.
- The block latches read_address_i, write_address_i, writedata_i and write_enable_i only on an accepted tick. Inputs may change freely afterwards.
- State machine (the wait counter reloads on every state entry):
  - IDLE: strobes inactive, bus not driven. A tick moves to READ.
  - READ: lasts READ_WAIT cycles. ce_n=0, oe_n=0, addr = latched read address, dq_oe=0. sram_dq_i is registered on the last READ cycle. Then go to TURN.
  - TURN: 1 cycle. ce_n=0, oe_n=1, dq_oe=0; bus turnaround. If the latched write_enable is 1, go to WRITE; otherwise go to IDLE.
  - WRITE: lasts WRITE_WAIT cycles. ce_n=0, we_n=0, oe_n=1, dq_oe=1, addr = latched write address, dq_o = latched writedata. Then go to WHOLD.
  - WHOLD: 1 cycle. we_n=1; addr, dq_o and dq_oe=1 are held for data hold time. Then go to IDLE, where ce_n=1 and dq_oe=0.
- A tick seen in any state other than IDLE is ignored and sets overrun_o. overrun_o clears only on reset.
- oe_n and we_n are never low in the same cycle. dq_oe is never 1 while oe_n=0.

## Timing
- Take the tick as cycle 0 in IDLE.
- READ occupies cycles 1..READ_WAIT. The data sample is taken at the clock edge that ends cycle READ_WAIT.
- readdata_o and readdata_valid_o=1 appear in cycle READ_WAIT+1, which is the TURN cycle. Read latency from tick is READ_WAIT+1 cycles.
- Without a write, IDLE is re-entered at cycle READ_WAIT+2. The next tick is accepted in that cycle.
- With a write:
  - WRITE occupies cycles READ_WAIT+2 .. READ_WAIT+WRITE_WAIT+1.
  - WHOLD occupies cycle READ_WAIT+WRITE_WAIT+2.
  - IDLE is re-entered at cycle READ_WAIT+WRITE_WAIT+3.
- With defaults, a full pair takes 7 cycles and a read-only pair takes 4 cycles. Both are far below one sample period.
- busy_o is 1 from cycle 1 through the last non-IDLE cycle.
- A tick on the same cycle IDLE is re-entered is accepted and does not count as an overrun.
- Reset asserted mid-operation (for example during WRITE):
  - All strobes go inactive and dq_oe goes to 0 asynchronously.
  - No readdata_valid_o pulse is issued for the aborted pair.
  - After reset release the block waits in IDLE for a new tick.
- Read and write to the same address in one pair: the read returns the old contents, because the read phase precedes the write.

## Test plan
- Reset check: assert rst_n_i=0 mid-WRITE -> in the same cycle sram_we_n_o=1, sram_dq_oe_o=0 and busy_o=0. Release reset and tick once -> normal 7-cycle pair.
- Read-only pair: preload the SRAM model with addr 0x00123 = 0xBEEF. Tick with read 0x00123 and write_enable=0 -> sram_oe_n_o low in cycles 1-2, readdata_o=0xBEEF with valid in cycle 3, sram_we_n_o never low, busy_o low again at cycle 4.
- Full pair: tick with read 0x1FFFFF, write 0x000010, data 0xA5A5, write_enable=1 -> we_n low in cycles 4-5, dq_o=0xA5A5 and addr=0x000010 held through cycle 6. The model then holds 0xA5A5 at 0x10.
- Same-address pair: addr 0x00400 holds 0x1111; tick with read=write=0x00400 and data 0x2222 -> readdata_o=0x1111, then the memory holds 0x2222.
- Overrun: tick at cycle 0 and again at cycle 3 -> the second tick is ignored, overrun_o=1 from cycle 4 and stays 1. A tick at cycle 7 is accepted.
- Bus contention monitor over 10,000 random ticks and addresses -> oe_n and we_n are never low together, dq_oe is never 1 while oe_n=0, and every read matches the scoreboard.
